// File: rtl/sdram_arbiter.sv
// One-transaction-at-a-time arbiter between N audio clients and the single-port SDRAM bus.
// Round-robin or fixed-priority grant. Every output, including the debug state, comes from a register.
module sdram_arbiter #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CLIENTS-1:0]        client_read,
  input  logic [NUM_CLIENTS-1:0]        client_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_writedata,
  output logic [NUM_CLIENTS-1:0]        client_finished,
  output logic [DATA_W-1:0]             client_readdata,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished,
  output logic [2:0]                    grant_idx,
  output logic                          busy,
  output logic                          protocol_error,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_GAP = 2'd2} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_CLIENTS - 1);

  state_t                 state;
  logic [2:0]             rr_ptr;
  logic [7:0]             req_ext;
  logic                   win_found;
  logic [2:0]             win_idx;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_wdata;
  logic                   win_rd;
  logic                   win_wr;
  logic [NUM_CLIENTS-1:0] fin_onehot;

  assign dbg_state = state;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_CLIENTS-1:0] = client_read | client_write;
  end

  // Search upward from rr_ptr with wrap; rr_ptr stays 0 in fixed-priority mode,
  // so the same loop yields "lowest index wins".
  always_comb begin
    logic [3:0] sum;
    sum       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      sum = {1'b0, rr_ptr} + 4'(i);
      if (sum > {1'b0, LAST_IDX}) sum = sum - 4'(NUM_CLIENTS);
      if (!win_found && req_ext[sum[2:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[2:0];
      end
    end
  end

  always_comb begin
    win_addr   = '0;
    win_wdata  = '0;
    win_rd     = 1'b0;
    win_wr     = 1'b0;
    fin_onehot = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (win_idx == 3'(k)) begin
        win_addr  = client_addr[k*ADDR_W +: ADDR_W];
        win_wdata = client_writedata[k*DATA_W +: DATA_W];
        win_rd    = client_read[k];
        win_wr    = client_write[k];
      end
      fin_onehot[k] = (grant_idx == 3'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      client_finished <= '0;
      client_readdata <= '0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
      grant_idx       <= '0;
      busy            <= 1'b0;
      protocol_error  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          client_finished <= '0;
          if (win_found) begin
            grant_idx       <= win_idx;
            sdram_addr      <= win_addr;
            sdram_writedata <= win_wdata;
            // A client asserting both ops gets a write and is flagged.
            sdram_write     <= win_wr;
            sdram_read      <= win_rd & ~win_wr;
            if (win_rd && win_wr) protocol_error <= 1'b1;
            busy            <= 1'b1;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (sdram_finished) begin
            sdram_read      <= 1'b0;
            sdram_write     <= 1'b0;
            client_finished <= fin_onehot;
            if (sdram_read) client_readdata <= sdram_readdata;
            if (RR_MODE != 0) rr_ptr <= (grant_idx == LAST_IDX) ? 3'd0 : grant_idx + 3'd1;
            state           <= ST_GAP;
          end
        end
        ST_GAP: begin
          client_finished <= '0;
          busy            <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin (N=5), fixed-priority (N=5) and N=8 wrap instances.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Round-robin, 5 clients
  logic [4:0]     c_read, c_write, c_fin;
  logic [5*23-1:0] c_addr;
  logic [5*32-1:0] c_wdata;
  logic [31:0]    c_rdata, s_wdata, s_rdata;
  logic [22:0]    s_addr;
  logic           s_read, s_write, s_fin, busy, perr;
  logic [2:0]     gidx;
  logic [1:0]     dstate;

  // Fixed priority, 5 clients
  logic [4:0]     f_read, f_write, f_cfin;
  logic [5*23-1:0] f_addr;
  logic [5*32-1:0] f_wdata;
  logic [31:0]    f_rdata, f_swdata, f_srdata;
  logic [22:0]    f_saddr;
  logic           f_sread, f_swrite, f_sfin, f_busy, f_perr;
  logic [2:0]     f_gidx;
  logic [1:0]     f_dstate;

  // Round-robin, 8 clients
  logic [7:0]     e_read, e_write, e_cfin;
  logic [8*23-1:0] e_addr;
  logic [8*32-1:0] e_wdata;
  logic [31:0]    e_rdata, e_swdata, e_srdata;
  logic [22:0]    e_saddr;
  logic           e_sread, e_swrite, e_sfin, e_busy, e_perr;
  logic [2:0]     e_gidx;
  logic [1:0]     e_dstate;

  sdram_arbiter #(.NUM_CLIENTS(5), .RR_MODE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .client_read(c_read), .client_write(c_write),
    .client_addr(c_addr), .client_writedata(c_wdata), .client_finished(c_fin),
    .client_readdata(c_rdata), .sdram_read(s_read), .sdram_write(s_write),
    .sdram_addr(s_addr), .sdram_writedata(s_wdata), .sdram_readdata(s_rdata),
    .sdram_finished(s_fin), .grant_idx(gidx), .busy(busy), .protocol_error(perr),
    .dbg_state(dstate));

  sdram_arbiter #(.NUM_CLIENTS(5), .RR_MODE(0)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n), .client_read(f_read), .client_write(f_write),
    .client_addr(f_addr), .client_writedata(f_wdata), .client_finished(f_cfin),
    .client_readdata(f_rdata), .sdram_read(f_sread), .sdram_write(f_swrite),
    .sdram_addr(f_saddr), .sdram_writedata(f_swdata), .sdram_readdata(f_srdata),
    .sdram_finished(f_sfin), .grant_idx(f_gidx), .busy(f_busy), .protocol_error(f_perr),
    .dbg_state(f_dstate));

  sdram_arbiter #(.NUM_CLIENTS(8), .RR_MODE(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .client_read(e_read), .client_write(e_write),
    .client_addr(e_addr), .client_writedata(e_wdata), .client_finished(e_cfin),
    .client_readdata(e_rdata), .sdram_read(e_sread), .sdram_write(e_swrite),
    .sdram_addr(e_saddr), .sdram_writedata(e_swdata), .sdram_readdata(e_srdata),
    .sdram_finished(e_sfin), .grant_idx(e_gidx), .busy(e_busy), .protocol_error(e_perr),
    .dbg_state(e_dstate));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    c_read = '0; c_write = '0; c_addr = '0; c_wdata = '0; s_rdata = '0; s_fin = 1'b0;
    f_read = '0; f_write = '0; f_addr = '0; f_wdata = '0; f_srdata = '0; f_sfin = 1'b0;
    e_read = '0; e_write = '0; e_addr = '0; e_wdata = '0; e_srdata = '0; e_sfin = 1'b0;
    apply_reset();
    checks++;
    if ({s_read, s_write, c_fin, busy, perr, gidx, dstate} !== 14'd0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 0", {s_read, s_write, c_fin, busy, perr, gidx, dstate});
    end
    checks++;
    if ({c_rdata, s_addr, s_wdata} !== 87'd0) begin
      errs++; $display("FAIL reset_data: got %h want 0", {c_rdata, s_addr, s_wdata});
    end
  endtask

  task automatic test_single_read();
    int hi;
    c_addr[4*23 +: 23] = 23'h000100;
    c_read[4] = 1'b1;
    tick();
    checks++;
    if ({s_read, s_write, gidx, busy} !== {1'b1, 1'b0, 3'd4, 1'b1}) begin
      errs++; $display("FAIL single_grant: got rd=%b wr=%b g=%0d busy=%b want 1 0 4 1", s_read, s_write, gidx, busy);
    end
    checks++;
    if (s_addr !== 23'h000100) begin
      errs++; $display("FAIL single_addr: got %h want 000100", s_addr);
    end
    hi = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_read) hi++;
    end
    s_rdata = 32'hDEADBEEF;
    s_fin = 1'b1;
    tick();
    s_fin = 1'b0;
    s_rdata = 32'h0;
    checks++;
    if (hi !== 4 || s_read !== 1'b0) begin
      errs++; $display("FAIL single_read_len: got %0d cycles (rd now %b) want 4 then 0", hi, s_read);
    end
    checks++;
    if (c_fin !== 5'b10000 || c_rdata !== 32'hDEADBEEF) begin
      errs++; $display("FAIL single_finish: got fin=%b data=%h want 10000 deadbeef", c_fin, c_rdata);
    end
    c_read[4] = 1'b0;
    tick();
    checks++;
    if (c_fin !== 5'b0 || c_rdata !== 32'hDEADBEEF || busy !== 1'b0 || dstate !== 2'd0) begin
      errs++; $display("FAIL single_after: got fin=%b data=%h busy=%b st=%0d want 0 deadbeef 0 0", c_fin, c_rdata, busy, dstate);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 3, 4, 0, 3, 4};
    int wait_c;
    apply_reset();
    c_read = 5'b11001;
    for (int n = 0; n < 6; n++) begin
      wait_c = 0;
      while (!s_read && wait_c < 10) begin
        tick();
        wait_c++;
      end
      checks++;
      if (!s_read) begin
        errs++; $display("FAIL rr_timeout: txn %0d no request after %0d cycles", n, wait_c);
      end
      checks++;
      if (gidx !== 3'(exp_g[n])) begin
        errs++; $display("FAIL rr_order: txn %0d got %0d want %0d", n, gidx, exp_g[n]);
      end
      if (n > 0) begin
        checks++;
        if (wait_c + 1 !== 3) begin
          errs++; $display("FAIL rr_spacing: txn %0d got %0d cycles want 3", n, wait_c + 1);
        end
      end
      s_fin = 1'b1;
      tick();
      s_fin = 1'b0;
      checks++;
      if (c_fin !== 5'(1 << exp_g[n])) begin
        errs++; $display("FAIL rr_finished: txn %0d got %b want %b", n, c_fin, 5'(1 << exp_g[n]));
      end
    end
    c_read = '0;
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    int wait_c;
    apply_reset();
    f_read[1] = 1'b1;
    f_write[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_c = 0;
      while (!(f_sread || f_swrite) && wait_c < 10) begin
        tick();
        wait_c++;
      end
      checks++;
      if (f_gidx !== 3'd1 || f_sread !== 1'b1 || f_swrite !== 1'b0) begin
        errs++; $display("FAIL fp_grant: txn %0d got g=%0d rd=%b wr=%b want 1 1 0", n, f_gidx, f_sread, f_swrite);
      end
      f_sfin = 1'b1;
      tick();
      f_sfin = 1'b0;
    end
    f_read[1] = 1'b0;
    wait_c = 0;
    while (!(f_sread || f_swrite) && wait_c < 10) begin
      tick();
      wait_c++;
    end
    checks++;
    if (f_gidx !== 3'd3 || f_swrite !== 1'b1) begin
      errs++; $display("FAIL fp_low_after: got g=%0d wr=%b want 3 1", f_gidx, f_swrite);
    end
    f_sfin = 1'b1;
    tick();
    f_sfin = 1'b0;
    f_write[3] = 1'b0;
    tick();
  endtask

  task automatic test_protocol_error();
    apply_reset();
    c_addr[3*23 +: 23] = 23'h00002A;
    c_wdata[3*32 +: 32] = 32'h12345678;
    c_read[3] = 1'b1;
    c_write[3] = 1'b1;
    tick();
    checks++;
    if ({s_write, s_read, perr} !== 3'b101 || s_wdata !== 32'h12345678 || s_addr !== 23'h00002A) begin
      errs++; $display("FAIL perr_issue: got wr=%b rd=%b perr=%b wd=%h a=%h want 1 0 1 12345678 2a", s_write, s_read, perr, s_wdata, s_addr);
    end
    s_rdata = 32'hFFFFFFFF;
    s_fin = 1'b1;
    tick();
    s_fin = 1'b0;
    s_rdata = 32'h0;
    checks++;
    if (c_fin !== 5'b01000 || c_rdata !== 32'h0) begin
      errs++; $display("FAIL perr_finish: got fin=%b data=%h want 01000 00000000", c_fin, c_rdata);
    end
    c_read[3] = 1'b0;
    c_write[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (perr !== 1'b1) begin
      errs++; $display("FAIL perr_sticky: got %b want 1", perr);
    end
    apply_reset();
    checks++;
    if (perr !== 1'b0) begin
      errs++; $display("FAIL perr_clear: got %b want 0", perr);
    end
  endtask

  task automatic test_reset_mid();
    c_read[2] = 1'b1;
    tick();
    tick();
    checks++;
    if (s_read !== 1'b1 || busy !== 1'b1 || dstate !== 2'd1) begin
      errs++; $display("FAIL mid_busy: got rd=%b busy=%b st=%0d want 1 1 1", s_read, busy, dstate);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({s_read, s_write, c_fin, busy, perr, gidx, dstate} !== 14'd0 || s_addr !== 23'd0) begin
      errs++; $display("FAIL mid_reset: got %b addr=%h want 0", {s_read, s_write, c_fin, busy, perr, gidx, dstate}, s_addr);
    end
    rst_n = 1'b1;
    c_read[2] = 1'b0;
    tick();
    s_fin = 1'b1;
    tick();
    s_fin = 1'b0;
    checks++;
    if (c_fin !== 5'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_stray: got fin=%b busy=%b want 0 0", c_fin, busy);
    end
    tick();
    checks++;
    if (c_fin !== 5'b0 || dstate !== 2'd0) begin
      errs++; $display("FAIL mid_stray2: got fin=%b st=%0d want 0 0", c_fin, dstate);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    e_read[6] = 1'b1;
    tick();
    checks++;
    if (e_gidx !== 3'd6 || e_sread !== 1'b1) begin
      errs++; $display("FAIL wrap_g6: got g=%0d rd=%b want 6 1", e_gidx, e_sread);
    end
    e_sfin = 1'b1;
    tick();
    e_sfin = 1'b0;
    e_read[6] = 1'b0;
    tick();
    e_read[7] = 1'b1;
    e_read[0] = 1'b1;
    tick();
    checks++;
    if (e_gidx !== 3'd7 || e_sread !== 1'b1) begin
      errs++; $display("FAIL wrap_g7: got g=%0d rd=%b want 7 1", e_gidx, e_sread);
    end
    e_sfin = 1'b1;
    tick();
    e_sfin = 1'b0;
    checks++;
    if (e_cfin !== 8'h80) begin
      errs++; $display("FAIL wrap_fin7: got %b want 10000000", e_cfin);
    end
    e_read[7] = 1'b0;
    tick();
    tick();
    checks++;
    if (e_gidx !== 3'd0 || e_sread !== 1'b1) begin
      errs++; $display("FAIL wrap_g0: got g=%0d rd=%b want 0 1", e_gidx, e_sread);
    end
    e_sfin = 1'b1;
    tick();
    e_sfin = 1'b0;
    e_read[0] = 1'b0;
    checks++;
    if (e_cfin !== 8'h01) begin
      errs++; $display("FAIL wrap_fin0: got %b want 00000001", e_cfin);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_protocol_error();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
